// File: rtl/async_ram_pkg.sv
// async_ram_pkg
// Shared definitions for the asynchronous SRAM initiator:
//   - state_t      : controller phase (IDLE, SETUP, ACCESS, TURN)
//   - DEF_*        : default widths and phase lengths
//   - cnt_width()  : width of the phase down-counter for given phase lengths
package async_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_ACCESS_CYC = 2;
  localparam int DEF_TURN_CYC   = 1;

  // The counter only ever holds (phase length - 1), so clog2(max+1) bits
  // suffice; never return less than one bit.
  function automatic int cnt_width(input int s, input int a, input int t);
    int m;
    m = s;
    if (a > m) m = a;
    if (t > m) m = t;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/async_ram_ctrl.sv
// async_ram_ctrl
// Synchronous initiator for a single-port asynchronous SRAM with
// level-sensitive strobes and a shared tri-state data bus.
// Each accepted request runs IDLE -> SETUP -> ACCESS -> TURN -> IDLE, with
// phase lengths SETUP_CYC / ACCESS_CYC / TURN_CYC.
// Ports:
//   clk_in, rst_in                 : clock, synchronous active-high reset
//   req_valid_in / req_ready_out   : request handshake (accepted only in IDLE)
//   req_we_in, req_addr_in, req_wdata_in : request fields, latched at accept
//   rsp_valid_out                  : one-cycle completion pulse (reads and writes)
//   rsp_rdata_out                  : last read data, changes only on read completion
//   ram_we_out, ram_enable_out     : registered RAM write / read strobes
//   ram_addr_out                   : registered RAM address
//   ram_data                       : shared RAM data bus
module async_ram_ctrl
  import async_ram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_we_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_wdata_in,
  output logic              rsp_valid_out,
  output logic [DATA_W-1:0] rsp_rdata_out,
  output logic              ram_we_out,
  output logic              ram_enable_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  inout  wire logic [DATA_W-1:0] ram_data
);

  localparam int CNT_W = cnt_width(SETUP_CYC, ACCESS_CYC, TURN_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  // Request fields captured at accept; addr_reg drives the RAM address pins
  // directly, so the address only ever moves on an accept edge (strobes low).
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;

  logic               ram_we_reg, ram_we_next;
  logic               ram_en_reg, ram_en_next;
  logic               drive_reg, drive_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]  rdata_reg;

  logic               accept;
  logic               last_cyc;
  logic               we_eff;

  assign accept   = (state_reg == ST_IDLE) && req_valid_in;
  assign last_cyc = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg != ST_IDLE && !last_cyc) begin
      cnt_next = cnt_reg - 1'b1;
    end
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid_in) begin
          state_next = ST_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (last_cyc) begin
          state_next = ST_ACCESS;
          cnt_next   = ACCESS_LD;
        end
      end
      ST_ACCESS: begin
        if (last_cyc) begin
          state_next = ST_TURN;
          cnt_next   = TURN_LD;
        end
      end
      ST_TURN: begin
        if (last_cyc) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    // RAM-side outputs are decoded from the upcoming state and registered,
    // so the pins change exactly at phase boundaries with no decode glitches.
    // On the accept edge the direction comes straight from the request.
    we_eff         = accept ? req_we_in : we_reg;
    ram_we_next    = (state_next == ST_ACCESS) && we_eff;
    ram_en_next    = (state_next == ST_ACCESS) && !we_eff;
    drive_next     = (state_next != ST_IDLE) && we_eff;
    rsp_valid_next = (state_reg == ST_ACCESS) && last_cyc;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      ram_we_reg    <= 1'b0;
      ram_en_reg    <= 1'b0;
      drive_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ram_we_reg    <= ram_we_next;
      ram_en_reg    <= ram_en_next;
      drive_reg     <= drive_next;
      rsp_valid_reg <= rsp_valid_next;
      if (accept) begin
        we_reg    <= req_we_in;
        addr_reg  <= req_addr_in;
        wdata_reg <= req_wdata_in;
      end
      // Sample the bus at the edge closing the last strobe cycle, while the
      // RAM is still being enabled.
      if (state_reg == ST_ACCESS && last_cyc && !we_reg) begin
        rdata_reg <= ram_data;
      end
    end
  end

  assign ram_data       = drive_reg ? wdata_reg : 'z;
  assign req_ready_out  = (state_reg == ST_IDLE);
  assign rsp_valid_out  = rsp_valid_reg;
  assign rsp_rdata_out  = rdata_reg;
  assign ram_we_out     = ram_we_reg;
  assign ram_enable_out = ram_en_reg;
  assign ram_addr_out   = addr_reg;

endmodule
